// File: rtl/seq_timer_ctrl_pkg.sv
// Shared types and constants for the cascaded-counter timer controller.
package seq_timer_ctrl_pkg;

    localparam int STAGE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/counter161_stage.sv
// 74LS161-style 4-bit synchronous counter stage: load beats count, counts on ent&enp.
// One cycle from ld_n/enables to q; rco is combinational from q and ent.
module counter161_stage
    import seq_timer_ctrl_pkg::*;
(
    input  logic               clk_50M,
    input  logic               rst_n,
    input  logic               ld_n,
    input  logic               ent,
    input  logic               enp,
    input  logic [STAGE_W-1:0] d,
    output logic [STAGE_W-1:0] q,
    output logic               rco
);

    logic [STAGE_W-1:0] q_q;

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (!ld_n) begin
            q_q <= d;
        end else if (ent && enp) begin
            q_q <= q_q + STAGE_W'(1);
        end
    end

    assign q   = q_q;
    assign rco = (&q_q) & ent;

endmodule

// File: rtl/seq_timer_ctrl.sv
// One-shot / periodic timer sequencing NSTAGE counter161 stages from a prescaled tick.
// Terminal tick registers co next cycle; stop aborts to IDLE next edge; pause freezes RUN.
module seq_timer_ctrl
    import seq_timer_ctrl_pkg::*;
#(
    parameter int NSTAGE   = 2,
    parameter int PRESCALE = 50,
    parameter int PSW      = 26
) (
    input  logic                      clk_50M,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      pause,
    input  logic                      auto_reload,
    input  logic [STAGE_W*NSTAGE-1:0] preset,
    output logic                      busy,
    output logic                      tick,
    output logic [STAGE_W*NSTAGE-1:0] count,
    output logic                      co,
    output logic                      done
);

    localparam int             W       = STAGE_W * NSTAGE;
    localparam logic [PSW-1:0] PS_LAST = PSW'(PRESCALE - 1);

    state_t            state_q, state_d;
    logic [W-1:0]      preset_q;
    logic [PSW-1:0]    presc_q, presc_d;
    logic              busy_q, done_q, co_q;
    logic              tc, cnt_en, ld_n;
    logic [NSTAGE-1:0] ent, rco;

    always_comb begin
        tick = (state_q == ST_RUN) && !pause && !stop && (presc_q == PS_LAST);
    end

    // Terminal tick: every stage full while ticking. One-shot completion
    // blocks the increment so the count rests at all ones.
    assign tc     = &rco;
    assign cnt_en = tick & ~tc;
    assign ld_n   = ~(~stop & ((state_q == ST_LOAD) | (tc & auto_reload)));

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_LOAD;
            ST_LOAD: begin
                state_d = ST_RUN;
                presc_d = '0;
            end
            ST_RUN: if (!pause) begin
                presc_d = tick ? '0 : presc_q + PSW'(1);
                if (tc && !auto_reload) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase
        if (stop) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            preset_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            co_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            co_q    <= tc;
            if (state_q == ST_IDLE && start && !stop) preset_q <= preset;
        end
    end

    // Carry lookahead: each stage's ent equals the previous stage's rco,
    // formed from the registered count so the chain has no combinational loop.
    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign ent[k] = tick;
        end else begin : g_next
            assign ent[k] = tick & (&count[STAGE_W*k-1:0]);
        end

        counter161_stage u_stage (
            .clk_50M (clk_50M),
            .rst_n   (rst_n),
            .ld_n    (ld_n),
            .ent     (ent[k]),
            .enp     (cnt_en),
            .d       (preset_q[STAGE_W*k +: STAGE_W]),
            .q       (count[STAGE_W*k +: STAGE_W]),
            .rco     (rco[k])
        );
    end

    assign busy = busy_q;
    assign done = done_q;
    assign co   = co_q;

endmodule
